// File: rtl/can_pkg.sv
// CAN TX shared definitions: serializer state encoding, field lengths, CRC-15 step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } tx_state_e;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
  localparam int CAN_ID_LEN   = 11;
  localparam int CAN_DLC_LEN  = 4;
  localparam int CAN_CRC_LEN  = 15;
  localparam int CAN_EOF_LEN  = 7;
  // Arbitration = ID + RTR; control = IDE + r0 + DLC.
  localparam int CAN_ARB_LEN  = CAN_ID_LEN + 1;
  localparam int CAN_CTRL_LEN = 2 + CAN_DLC_LEN;

  // One serial CRC-15 step, MSB-first.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    crc15_step = {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? CAN_CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 accumulator for the CAN frame body.
// Latency: crc reflects bit_in one cycle after an en cycle; clr has priority over en.
// Backpressure: none; caller gates en.
// Ports: clk, rst_n (sync, active-low), clr, en, bit_in -> crc[14:0].
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 15'h0000;
    end else if (clr) begin
      crc <= 15'h0000;
    end else if (en) begin
      crc <= crc15_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/can_tx_serializer.sv
// CAN 2.0A base data frame serializer (SOF..IFS), MSB-first, one bit per advance.
// Latency: SOF on bit_out the cycle after tx_start in IDLE; each advance shows the next bit one cycle later.
// Backpressure: stuff_hold on a sample_point freezes bit, counter and CRC for that strobe.
// Ports: clk, rst_n, tx_start, tx_id[10:0], tx_dlc[3:0], tx_data[63:0] (byte0 = [63:56]),
//        sample_point, stuff_hold, rx_bit -> bit_out, stuff_en, tx_busy, tx_done, ack_err.
module can_tx_serializer
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int IFS_BITS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        sample_point,
  input  logic        stuff_hold,
  input  logic        rx_bit,
  output logic        bit_out,
  output logic        stuff_en,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        ack_err
);

  tx_state_e   state, state_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic [6:0]  field_len;
  logic        last, adv;
  logic [10:0] id_q;
  logic [3:0]  dlc_q, nbytes;
  logic [63:0] data_q;
  logic [5:0]  ctrl_word;
  logic [14:0] crc_q, crc_upd;
  logic        crc_en, crc_clr, nxt_bit;

  assign adv       = sample_point & ~stuff_hold;
  assign nbytes    = (dlc_q > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_q;
  assign ctrl_word = {2'b00, dlc_q};
  assign crc_clr   = (state == ST_IDLE) && tx_start;
  assign crc_en    = adv && (state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA});
  // bit_out is registered from next-state values, so the first CRC bit must
  // see the CRC including the bit being consumed on this same edge.
  assign crc_upd   = crc_en ? crc15_step(crc_q, bit_out) : crc_q;

  can_crc15 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (bit_out),
    .crc    (crc_q)
  );

  always_comb begin
    field_len = 7'd1;
    case (state)
      ST_ARB:  field_len = 7'(CAN_ARB_LEN);
      ST_CTRL: field_len = 7'(CAN_CTRL_LEN);
      ST_DATA: field_len = {nbytes, 3'b000};
      ST_CRC:  field_len = 7'(CAN_CRC_LEN);
      ST_EOF:  field_len = 7'(CAN_EOF_LEN);
      ST_IFS:  field_len = 7'(IFS_BITS);
      default: field_len = 7'd1;
    endcase
  end

  assign last = (cnt == field_len - 7'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 7'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_IDLE) begin
      if (tx_start) begin
        state_nxt = ST_SOF;
        cnt_nxt   = 7'd0;
      end
    end else if (adv) begin
      if (last) begin
        cnt_nxt = 7'd0;
        case (state)
          ST_SOF:      state_nxt = ST_ARB;
          ST_ARB:      state_nxt = ST_CTRL;
          ST_CTRL:     state_nxt = (nbytes == 4'd0) ? ST_CRC : ST_DATA;
          ST_DATA:     state_nxt = ST_CRC;
          ST_CRC:      state_nxt = ST_CRC_DEL;
          ST_CRC_DEL:  state_nxt = ST_ACK_SLOT;
          ST_ACK_SLOT: state_nxt = ST_ACK_DEL;
          ST_ACK_DEL:  state_nxt = ST_EOF;
          ST_EOF:      state_nxt = ST_IFS;
          default:     state_nxt = ST_IDLE;
        endcase
      end else begin
        cnt_nxt = cnt + 7'd1;
      end
    end
  end

  // Bit that will be on the wire after this edge. Latched fields are only
  // read in ARB and later, never on the IDLE->SOF edge that loads them.
  always_comb begin
    nxt_bit = 1'b1;
    case (state_nxt)
      ST_SOF:  nxt_bit = 1'b0;
      ST_ARB:  nxt_bit = (cnt_nxt < 7'(CAN_ID_LEN)) ? id_q[4'd10 - cnt_nxt[3:0]] : 1'b0;
      ST_CTRL: nxt_bit = ctrl_word[3'd5 - cnt_nxt[2:0]];
      ST_DATA: nxt_bit = data_q[~cnt_nxt[5:0]];
      ST_CRC:  nxt_bit = crc_upd[4'd14 - cnt_nxt[3:0]];
      default: nxt_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q   <= 11'h000;
      dlc_q  <= 4'h0;
      data_q <= 64'h0;
    end else if ((state == ST_IDLE) && tx_start) begin
      id_q   <= tx_id;
      dlc_q  <= tx_dlc;
      data_q <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_out  <= 1'b1;
      stuff_en <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      bit_out  <= nxt_bit;
      stuff_en <= state_nxt inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
      tx_busy  <= (state_nxt != ST_IDLE);
      tx_done  <= adv && (state == ST_IFS) && last;
      ack_err  <= adv && (state == ST_ACK_SLOT) && rx_bit;
    end
  end

endmodule

// File: tb/tb_can_tx_serializer.sv
module tb_can_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n, tx_start, sample_point, stuff_hold, rx_bit;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        bit_out, stuff_en, tx_busy, tx_done, ack_err;

  always #5 clk = ~clk;

  can_tx_serializer #(.MAX_BYTES(8), .IFS_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc),
    .tx_data(tx_data), .sample_point(sample_point), .stuff_hold(stuff_hold),
    .rx_bit(rx_bit), .bit_out(bit_out), .stuff_en(stuff_en), .tx_busy(tx_busy),
    .tx_done(tx_done), .ack_err(ack_err)
  );

  typedef struct { bit b; bit se; } exp_bit_t;
  typedef struct { int nbits; int acks; int holds; } exp_frame_t;

  exp_bit_t   exp_q[$];
  exp_frame_t frm_q[$];

  int checks = 0, errors = 0;
  int adv_cnt = 0, ack_cnt = 0, hold_cnt = 0, done_cnt = 0;
  bit stuffer_on = 0;
  int force_holds = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: builds bit list and CRC independently of the DUT.
  task automatic push_frame(input logic [10:0] id, input logic [3:0] dlc,
                            input logic [63:0] data, input int acks,
                            input int holds, input int exp_len);
    bit          bits[$];
    logic [15:0] r;
    logic [14:0] crc;
    int          nb, se_len;
    exp_bit_t    e;
    exp_frame_t  f;
    crc = 15'h0;
    nb  = (dlc > 4'd8) ? 8 : int'(dlc);
    bits.push_back(1'b0);
    for (int i = 10; i >= 0; i--) bits.push_back(id[i]);
    bits.push_back(1'b0);
    bits.push_back(1'b0);
    bits.push_back(1'b0);
    for (int i = 3; i >= 0; i--) bits.push_back(dlc[i]);
    for (int i = 0; i < 8 * nb; i++) bits.push_back(data[63 - i]);
    foreach (bits[i]) begin
      r = {crc, 1'b0};
      if (bits[i] ^ crc[14]) r[14:0] = r[14:0] ^ 15'h4599;
      crc = r[14:0];
    end
    for (int i = 14; i >= 0; i--) bits.push_back(crc[i]);
    se_len = bits.size();
    for (int i = 0; i < 13; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      e.b  = bits[i];
      e.se = (i < se_len);
      exp_q.push_back(e);
    end
    f.nbits = exp_len;
    f.acks  = acks;
    f.holds = holds;
    frm_q.push_back(f);
  endtask

  task automatic start_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    @(posedge clk); #1;
    tx_id = id; tx_dlc = dlc; tx_data = data; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0; tx_id = ~id; tx_dlc = ~dlc; tx_data = ~data;
    @(negedge clk);
    chk("sof_busy", tx_busy, 1);
    chk("sof_bit", bit_out, 0);
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no tx_done expected one", name);
    end
  endtask

  task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                      input int acks, input int holds, input int exp_len,
                      input bit spurious, input string name);
    int d0;
    d0 = done_cnt;
    push_frame(id, dlc, data, acks, holds, exp_len);
    start_frame(id, dlc, data);
    if (spurious) begin
      repeat (40) @(posedge clk);
      #1;
      tx_id = 11'h7FF; tx_dlc = 4'h0; tx_data = 64'h0; tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
    end
    wait_done(d0, name);
    repeat (5) @(posedge clk);
  endtask

  // Strobe source plus a behavioural bit stuffer (stuff_hold after 5 equal bits).
  initial begin
    int phase;
    int run;
    bit last_b, pend;
    phase = 0; run = 0; last_b = 1'b1; pend = 1'b0;
    sample_point = 1'b0;
    stuff_hold   = 1'b0;
    forever begin
      @(posedge clk); #1;
      sample_point = 1'b0;
      stuff_hold   = 1'b0;
      if (!tx_busy) begin
        run = 0; last_b = 1'b1; pend = 1'b0;
      end
      phase = (phase + 1) % 4;
      if (phase == 0) begin
        sample_point = 1'b1;
        if (stuffer_on && pend) begin
          stuff_hold = 1'b1; pend = 1'b0; last_b = ~last_b; run = 1;
        end else if (force_holds > 0 && tx_busy && adv_cnt >= 5) begin
          stuff_hold = 1'b1;
          force_holds--;
        end else if (tx_busy && stuff_en) begin
          if (bit_out == last_b) run++;
          else begin
            last_b = bit_out; run = 1;
          end
          if (run == 5) pend = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expected bits on every advance, frame records on tx_done.
  initial begin
    exp_bit_t   e;
    exp_frame_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        adv_cnt = 0; ack_cnt = 0; hold_cnt = 0;
      end else begin
        if (ack_err) ack_cnt++;
        if (tx_done) begin
          done_cnt++;
          chk("done_busy", tx_busy, 0);
          if (frm_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_done: got tx_done expected none");
          end else begin
            f = frm_q.pop_front();
            chk("frame_len", adv_cnt, f.nbits);
            chk("ack_err_count", ack_cnt, f.acks);
            if (f.holds >= 0) chk("hold_count", hold_cnt, f.holds);
          end
          adv_cnt = 0; ack_cnt = 0; hold_cnt = 0;
        end
        if (sample_point && tx_busy) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_bit: got bit %0d expected end of frame", bit_out);
          end else if (stuff_hold) begin
            hold_cnt++;
            chk($sformatf("frozen_bit[%0d]", adv_cnt), bit_out, exp_q[0].b);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("bit[%0d]", adv_cnt), bit_out, e.b);
            chk($sformatf("stuff_en[%0d]", adv_cnt), stuff_en, e.se);
            adv_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int d0;
    rst_n = 1'b0; tx_start = 1'b0; tx_id = '0; tx_dlc = '0; tx_data = '0; rx_bit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bit_out", bit_out, 1);
    chk("rst_stuff_en", stuff_en, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ack_err", ack_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic DLC=0 frame.
    send(11'h123, 4'h0, 64'h0, 0, 0, 47, 1'b0, "dlc0");
    // All-ones ID with 8 bytes, stuffer active.
    stuffer_on = 1'b1;
    send(11'h7FF, 4'h8, 64'hAAAA_AAAA_AAAA_AAAA, 0, -1, 111, 1'b0, "dlc8_stuffed");
    stuffer_on = 1'b0;
    // Three holds mid-arbitration.
    force_holds = 3;
    send(11'h123, 4'h0, 64'h0, 0, 3, 47, 1'b0, "holds");
    // Missing ACK.
    rx_bit = 1'b1;
    send(11'h555, 4'h1, 64'h5A00_0000_0000_0000, 1, 0, 55, 1'b0, "ack_err");
    rx_bit = 1'b0;
    // DLC above 8 clamps payload, tx_start during busy ignored.
    send(11'h0F0, 4'hC, 64'h0123_4567_89AB_CDEF, 0, 0, 111, 1'b1, "dlc12");

    // Reset during DATA discards the frame.
    push_frame(11'h2AA, 4'h2, 64'hC3A5_0000_0000_0000, 0, 0, 63);
    start_frame(11'h2AA, 4'h2, 64'hC3A5_0000_0000_0000);
    for (int i = 0; i < 2000 && adv_cnt < 22; i++) @(posedge clk);
    chk("reach_data", (adv_cnt >= 22), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    frm_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_bit_out", bit_out, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_stuff_en", stuff_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send(11'h123, 4'h0, 64'h0, 0, 0, 47, 1'b0, "after_reset");

    d0 = done_cnt;
    repeat (20) @(posedge clk);
    chk("no_extra_done", done_cnt, d0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
